// File: rtl/lru_replacement_engine.sv
// Multi-set true-LRU / FIFO replacement engine with per-request lock masks.
// Victim requests go through a three-state handshake FSM.

module lru_perm_checker #(
  parameter int NUM_WAYS = 8,
  parameter int NUM_SETS = 64,
  parameter int AGE_W    = 3
) (
  input logic                               clk,
  input logic                               reset_n,
  input logic [NUM_SETS*NUM_WAYS*AGE_W-1:0] ages_flat
);
  localparam int ROW_W = NUM_WAYS * AGE_W;

  function automatic logic is_perm(input logic [ROW_W-1:0] row);
    logic [NUM_WAYS-1:0] seen;
    seen = {NUM_WAYS{1'b0}};
    for (int w = 0; w < NUM_WAYS; w++) begin
      seen[row[w*AGE_W +: AGE_W]] = 1'b1;
    end
    return &seen;
  endfunction

  // Each set must hold every age value exactly once.
  always @(posedge clk) begin
    if (reset_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        assert (is_perm(ages_flat[s*ROW_W +: ROW_W]));
      end
    end
  end
endmodule

module lru_replacement_engine #(
  parameter int  NUM_WAYS = 8,
  parameter int  NUM_SETS = 64,
  localparam int AGE_W    = $clog2(NUM_WAYS),
  localparam int SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mode_fifo,
  input  logic                upd_valid,
  input  logic [1:0]          upd_kind,
  input  logic [SET_W-1:0]    upd_set,
  input  logic [AGE_W-1:0]    upd_way,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_W-1:0]    req_set,
  input  logic [NUM_WAYS-1:0] req_lock,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [AGE_W-1:0]    rsp_way,
  output logic                rsp_none
);
  typedef logic [AGE_W-1:0] age_t;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [SET_W:0] SET_LIM = (SET_W+1)'(NUM_SETS);
  localparam age_t           AGE_MAX = age_t'(NUM_WAYS - 1);

  age_t                ages_r     [NUM_SETS][NUM_WAYS];
  age_t                ages_nxt_s [NUM_SETS][NUM_WAYS];
  age_t                search_row_s [NUM_WAYS];
  state_t              state_r, state_nxt_s;
  logic [SET_W-1:0]    req_set_r;
  logic [NUM_WAYS-1:0] req_lock_r;
  logic                req_ready_r, rsp_valid_r, rsp_none_r;
  age_t                rsp_way_r;
  logic                upd_set_ok_s, req_set_ok_s, touch_s, inval_s, accept_s;
  age_t                upd_age_s, sel_way_s, sel_age_s;
  logic                sel_none_s;
  logic [NUM_SETS*NUM_WAYS*AGE_W-1:0] ages_flat_s;

  assign upd_set_ok_s = ({1'b0, upd_set} < SET_LIM);
  assign req_set_ok_s = ({1'b0, req_set_r} < SET_LIM);
  assign touch_s  = upd_valid && upd_set_ok_s &&
                    ((upd_kind == 2'b01) || ((upd_kind == 2'b00) && !mode_fifo));
  assign inval_s  = upd_valid && upd_set_ok_s && (upd_kind == 2'b10);
  assign accept_s = req_valid && req_ready_r && (state_r == ST_IDLE);

  // Next-age computation for the updated set; all other sets hold.
  always_comb begin
    ages_nxt_s = ages_r;
    if (upd_set_ok_s) begin
      upd_age_s = ages_r[upd_set][upd_way];
    end else begin
      upd_age_s = {AGE_W{1'b0}};
    end
    if (touch_s) begin
      for (int v = 0; v < NUM_WAYS; v++) begin
        if (age_t'(v) == upd_way) begin
          ages_nxt_s[upd_set][v] = {AGE_W{1'b0}};
        end else if (ages_r[upd_set][v] < upd_age_s) begin
          ages_nxt_s[upd_set][v] = ages_r[upd_set][v] + age_t'(1);
        end else begin
          ages_nxt_s[upd_set][v] = ages_r[upd_set][v];
        end
      end
    end else if (inval_s) begin
      for (int v = 0; v < NUM_WAYS; v++) begin
        if (age_t'(v) == upd_way) begin
          ages_nxt_s[upd_set][v] = AGE_MAX;
        end else if (ages_r[upd_set][v] > upd_age_s) begin
          ages_nxt_s[upd_set][v] = ages_r[upd_set][v] - age_t'(1);
        end else begin
          ages_nxt_s[upd_set][v] = ages_r[upd_set][v];
        end
      end
    end else begin
      ages_nxt_s = ages_r;
    end
  end

  // Age storage; reset makes way w carry age w in every set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          ages_r[s][w] <= age_t'(w);
        end
      end
    end else begin
      ages_r <= ages_nxt_s;
    end
  end

  // Search reads the forwarded ages so a same-cycle update is honoured.
  always_comb begin
    for (int v = 0; v < NUM_WAYS; v++) begin
      search_row_s[v] = {AGE_W{1'b0}};
    end
    if (req_set_ok_s) begin
      for (int v = 0; v < NUM_WAYS; v++) begin
        search_row_s[v] = ages_nxt_s[req_set_r][v];
      end
    end else begin
      for (int v = 0; v < NUM_WAYS; v++) begin
        search_row_s[v] = {AGE_W{1'b0}};
      end
    end
  end

  // Oldest unlocked way wins; ages are unique so there are no ties.
  always_comb begin
    sel_none_s = 1'b1;
    sel_way_s  = {AGE_W{1'b0}};
    sel_age_s  = {AGE_W{1'b0}};
    for (int v = 0; v < NUM_WAYS; v++) begin
      if (!req_lock_r[v] && (sel_none_s || (search_row_s[v] > sel_age_s))) begin
        sel_none_s = 1'b0;
        sel_way_s  = age_t'(v);
        sel_age_s  = search_row_s[v];
      end else begin
        sel_none_s = sel_none_s;
      end
    end
    if (!req_set_ok_s) begin
      sel_none_s = 1'b1;
      sel_way_s  = {AGE_W{1'b0}};
    end else begin
      sel_way_s  = sel_way_s;
    end
  end

  // Request FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_SEARCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEARCH: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Request capture at acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_set_r  <= {SET_W{1'b0}};
      req_lock_r <= {NUM_WAYS{1'b0}};
    end else if (accept_s) begin
      req_set_r  <= req_set;
      req_lock_r <= req_lock;
    end else begin
      req_set_r  <= req_set_r;
      req_lock_r <= req_lock_r;
    end
  end

  // Registered handshake and response; response only loads in SEARCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_way_r   <= {AGE_W{1'b0}};
      rsp_none_r  <= 1'b0;
    end else begin
      req_ready_r <= (state_nxt_s == ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      if (state_r == ST_SEARCH) begin
        rsp_way_r  <= sel_way_s;
        rsp_none_r <= sel_none_s;
      end else begin
        rsp_way_r  <= rsp_way_r;
        rsp_none_r <= rsp_none_r;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_way   = rsp_way_r;
  assign rsp_none  = rsp_none_r;

  // Flattened view of the age array for the permutation checker.
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        ages_flat_s[(s*NUM_WAYS+w)*AGE_W +: AGE_W] = ages_r[s][w];
      end
    end
  end

  lru_perm_checker #(
    .NUM_WAYS (NUM_WAYS),
    .NUM_SETS (NUM_SETS),
    .AGE_W    (AGE_W)
  ) u_perm_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .ages_flat (ages_flat_s)
  );
endmodule

// File: tb/tb_lru_replacement_engine.sv
// Bench for lru_replacement_engine: a recency-list model (MRU at the front,
// LRU at the back) checked every cycle, plus directed literal expectations.

module tb_lru_replacement_engine;
  localparam int NW = 8;
  localparam int NS = 64;
  localparam int AW = 3;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          mode_fifo = 1'b0;
  logic          upd_valid = 1'b0;
  logic [1:0]    upd_kind = 2'b00;
  logic [SW-1:0] upd_set = '0;
  logic [AW-1:0] upd_way = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [SW-1:0] req_set = '0;
  logic [NW-1:0] req_lock = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [AW-1:0] rsp_way;
  logic          rsp_none;

  lru_replacement_engine #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clk(clk), .reset_n(reset_n), .mode_fifo(mode_fifo),
    .upd_valid(upd_valid), .upd_kind(upd_kind), .upd_set(upd_set), .upd_way(upd_way),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_way(rsp_way), .rsp_none(rsp_none)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: per-set recency list of way numbers, plus request progress.
  int            lst [NS][$];
  int            m_phase;
  bit            m_ready, m_valid, m_none;
  int            m_way, m_set;
  logic [NW-1:0] m_lock;
  bit            cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      lst[s].delete();
      for (int w = 0; w < NW; w++) lst[s].push_back(w);
    end
    m_phase = 0; m_ready = 1'b0; m_valid = 1'b0; m_none = 1'b0; m_way = 0;
  endfunction

  function automatic void list_remove(input int s, input int w);
    for (int i = 0; i < lst[s].size(); i++) begin
      if (lst[s][i] == w) begin
        lst[s].delete(i);
        break;
      end
    end
  endfunction

  function automatic int model_age(input int s, input int w);
    for (int i = 0; i < lst[s].size(); i++) if (lst[s][i] == w) return i;
    return -1;
  endfunction

  function automatic void model_step();
    bit acc;
    acc = (m_phase == 0) && m_ready && req_valid;
    if (upd_valid) begin
      if (upd_kind == 2'b01 || (upd_kind == 2'b00 && !mode_fifo)) begin
        list_remove(int'(upd_set), int'(upd_way));
        lst[upd_set].push_front(int'(upd_way));
      end else if (upd_kind == 2'b10) begin
        list_remove(int'(upd_set), int'(upd_way));
        lst[upd_set].push_back(int'(upd_way));
      end
    end
    case (m_phase)
      0: if (acc) begin m_set = int'(req_set); m_lock = req_lock; m_phase = 1; end
      1: begin
        m_none = 1'b1; m_way = 0;
        for (int i = NW - 1; i >= 0; i--) begin
          if (!m_lock[lst[m_set][i]]) begin
            m_way = lst[m_set][i]; m_none = 1'b0;
            break;
          end
        end
        m_phase = 2;
      end
      default: if (rsp_ready) m_phase = 0;
    endcase
    m_ready = (m_phase == 0);
    m_valid = (m_phase == 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_req_ready", int'(req_ready), int'(m_ready));
      check("cyc_rsp_valid", int'(rsp_valid), int'(m_valid));
      if (m_valid) begin
        check("cyc_rsp_way", int'(rsp_way), m_way);
        check("cyc_rsp_none", int'(rsp_none), int'(m_none));
      end
    end
  end

  task automatic upd(input logic [1:0] k, input int s, input int w);
    upd_valid = 1'b1; upd_kind = k; upd_set = SW'(s); upd_way = AW'(w);
    tick();
    upd_valid = 1'b0;
  endtask

  // Issue one request; optional hit in the SEARCH cycle; optional hold in RESP.
  task automatic do_req(input string name, input int s, input logic [NW-1:0] lock,
                        input int exp_way, input bit exp_none, input bit sup,
                        input int sup_way, input int hold);
    int n;
    check({name, "_ready"}, int'(req_ready), 1);
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_set = SW'(s); req_lock = lock;
    tick();
    req_valid = 1'b0;
    upd_valid = 1'b0;
    check({name, "_searching"}, int'(rsp_valid), 0);
    if (sup) begin
      upd_valid = 1'b1; upd_kind = 2'b00; upd_set = SW'(s); upd_way = AW'(sup_way);
    end
    n = 0;
    do begin
      tick();
      upd_valid = 1'b0;
      n++;
    end while (!rsp_valid && n < 6);
    check({name, "_latency"}, n + 1, 2);
    check({name, "_way"}, int'(rsp_way), exp_way);
    check({name, "_none"}, int'(rsp_none), int'(exp_none));
    for (int i = 0; i < hold; i++) begin
      upd_valid = 1'b1; upd_kind = 2'b00; upd_set = SW'(s); upd_way = AW'(NW - 1 - i);
      tick();
      check({name, "_held_valid"}, int'(rsp_valid), 1);
      check({name, "_held_way"}, int'(rsp_way), exp_way);
    end
    upd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check({name, "_done"}, int'(rsp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1 reset_n = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    repeat (3) tick();
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_way", int'(rsp_way), 0);
    check("rst_rsp_none", int'(rsp_none), 0);
    reset_n = 1'b1;
    check("rel_req_ready_low", int'(req_ready), 0);
    tick();
    check("rel_req_ready_high", int'(req_ready), 1);

    do_req("t1", 3, 8'h00, 7, 1'b0, 1'b0, 0, 0);

    upd(2'b00, 3, 7);
    check("t2_model_age7", model_age(3, 7), 0);
    check("t2_model_age0", model_age(3, 0), 1);
    do_req("t2", 3, 8'h00, 6, 1'b0, 1'b0, 0, 0);

    do_req("t3a", 5, 8'h80, 6, 1'b0, 1'b0, 0, 0);
    do_req("t3b", 5, 8'hFF, 0, 1'b1, 1'b0, 0, 0);

    mode_fifo = 1'b1;
    upd(2'b00, 2, 7);
    do_req("t4a", 2, 8'h00, 7, 1'b0, 1'b0, 0, 0);
    upd(2'b01, 2, 7);
    do_req("t4b", 2, 8'h00, 6, 1'b0, 1'b0, 0, 0);
    mode_fifo = 1'b0;

    upd(2'b10, 1, 0);
    check("t5_model_age0", model_age(1, 0), 7);
    check("t5_model_age1", model_age(1, 1), 0);
    do_req("t5", 1, 8'h00, 0, 1'b0, 1'b0, 0, 0);

    upd(2'b11, 7, 7);
    do_req("kind11", 7, 8'h00, 7, 1'b0, 1'b0, 0, 0);

    do_req("search_fwd", 6, 8'h00, 6, 1'b0, 1'b1, 7, 0);

    upd_valid = 1'b1; upd_kind = 2'b00; upd_set = SW'(8); upd_way = AW'(7);
    do_req("accept_upd", 8, 8'h00, 6, 1'b0, 1'b0, 0, 0);

    do_req("lock_c0", 9, 8'hC0, 5, 1'b0, 1'b0, 0, 0);

    do_req("t6_hold", 4, 8'h00, 7, 1'b0, 1'b0, 0, 5);

    req_valid = 1'b1; req_set = SW'(4); req_lock = 8'h00;
    tick();
    req_valid = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_rsp_valid", int'(rsp_valid), 0);
    check("t6_rst_req_ready", int'(req_ready), 0);
    for (int w = 0; w < NW; w++) check("t6_rst_age", int'(dut.ages_r[4][w]), w);
    tick();
    reset_n = 1'b1;
    tick();
    do_req("t6_after", 4, 8'h00, 7, 1'b0, 1'b0, 0, 0);
    do_req("t6_set3", 3, 8'h80, 6, 1'b0, 1'b0, 0, 0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
